pc_seq_unit: RTL and testbench
==============================

Name: pc_seq_unit

Overview:
- Parametrised program-counter sequencer for the MIPS datapath. It holds the PC register and forms the next PC from one of five sources: sequential, branch, region jump, register jump, or return.
- Jump-target concatenation is generalised: region bits of PC+4 are followed by the instruction index and then 2'b00.
- Adds a small return-address stack (RAS) that pushes on link and pops on return.
- Sits between the control unit and instruction memory; replaces the separate PC register and jump-target concat blocks.

Parameters:
- ADDR_W, 32, PC/address width; must satisfy ADDR_W > IDX_W+2.
- IDX_W, 26, jump instruction-index width.
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-low.
- stall_i  in  1  hold PC and RAS this cycle.
- branch_i  in  1  taken conditional branch.
- branch_off_i  in  16  signed word offset from instr[15:0].
- jump_i  in  1  region jump (j/jal).
- jump_idx_i  in  IDX_W  instr[IDX_W-1:0].
- jr_i  in  1  register jump (jr/jalr).
- jr_addr_i  in  ADDR_W  rs value.
- ret_i  in  1  qualifies jr_i as a return (jr $ra); use RAS.
- link_i  in  1  push return address (jal/jalr).
- pc_o  out  ADDR_W  current PC, registered.
- pc_plus4_o  out  ADDR_W  pc_o+4, combinational, mod 2^ADDR_W.
- ras_top_o  out  ADDR_W  top RAS entry; 0 when empty.
- ras_count_o  out  $clog2(RAS_DEPTH)+1  valid entries.
- ras_empty_o  out  1  count==0.
- ras_full_o  out  1  count==RAS_DEPTH.
- ras_err_o  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset: on a rising edge with rst_i=0, pc_o=RESET_PC, all RAS entries=0, count=0, ras_err_o=0. Reset overrides stall and every other input, including mid-stall and mid-push.
- Stall: stall_i=1 leaves pc_o, RAS contents, count and err unchanged. All other inputs are ignored.
- Next-PC priority when not stalled: jr_i > jump_i > branch_i > sequential. The new value is registered into pc_o at the edge, so there is 1-cycle latency.
  - Sequential: pc_plus4_o.
  - Branch: pc_plus4_o + (sign-extend(branch_off_i) << 2), truncated to ADDR_W (wraps).
  - Jump: {pc_plus4_o[ADDR_W-1:IDX_W+2], jump_idx_i, 2'b00}.
  - jr_i with ret_i=0: jr_addr_i.
  - jr_i with ret_i=1 and RAS non-empty: target = ras_top_o; pop (count-1).
  - jr_i with ret_i=1 and RAS empty: target = jr_addr_i; no pop; ras_err_o set.
  - ret_i without jr_i: ignored.
- Push: link_i=1 together with jump_i or jr_i pushes pc_plus4_o. link_i alone is ignored.
- Push when full: circular buffer; the oldest entry is overwritten, count stays RAS_DEPTH, ras_err_o set.
- Pop and push in the same cycle (jalr $ra with ret_i): top entry is replaced by pc_plus4_o; count unchanged; target = old top.
- Two-bit alignment: pc_o[1:0] always 0 for jump and branch targets. jr_addr_i is passed through unmodified.
- ras_err_o clears only on reset.

Test Plan:
- Reset/sequential: rst_i=0 one edge, then 3 free edges with RESET_PC=0 -> pc_o 0, 4, 8, 0xC; ras_count_o=0, ras_err_o=0.
- Branch with wrap: pc_o=0x100, branch_off_i=0xFFFE -> pc_o=0xFC. pc_o=0xFFFFFFFC, off=0x0001 -> pc_o=0x4.
- Region jump and link: pc_o=0x3000_0010, jump_i=1, link_i=1, jump_idx_i=0x0000040 -> pc_o=0x3000_0100; ras_top_o=0x3000_0014; ras_count_o=1.
- Return: next cycle jr_i=1, ret_i=1, jr_addr_i=0xDEAD0000 -> pc_o=0x3000_0014; ras_empty_o=1. A second return -> pc_o=0xDEAD0000, ras_err_o=1.
- Overflow: 5 jal pushes with RAS_DEPTH=4 -> ras_count_o=4, ras_full_o=1, ras_err_o=1. Four returns yield the last 4 return addresses in LIFO order.
- Stall/priority/reset: stall_i=1 with jump_i=1 -> pc_o and RAS unchanged. jr_i=1 with jump_i=1 and branch_i=1 -> pc_o=jr_addr_i. rst_i=0 while stall_i=1 -> pc_o=RESET_PC, count=0.

Source files
------------

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: PC register, next-PC selection (sequential, branch,
// region jump, register jump, return) and a circular return-address stack.
module pc_seq_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                IDX_W     = 26,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       branch_i,
  input  logic [15:0]                branch_off_i,
  input  logic                       jump_i,
  input  logic [IDX_W-1:0]           jump_idx_i,
  input  logic                       jr_i,
  input  logic [ADDR_W-1:0]          jr_addr_i,
  input  logic                       ret_i,
  input  logic                       link_i,
  output logic [ADDR_W-1:0]          pc_o,
  output logic [ADDR_W-1:0]          pc_plus4_o,
  output logic [ADDR_W-1:0]          ras_top_o,
  output logic [$clog2(RAS_DEPTH):0] ras_count_o,
  output logic                       ras_empty_o,
  output logic                       ras_full_o,
  output logic                       ras_err_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;   // index of the top entry when the stack is non-empty
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  logic [ADDR_W-1:0]        w_pc_plus4;
  logic signed [ADDR_W-1:0] w_off_ext;
  logic [ADDR_W-1:0]        w_br_target;
  logic [ADDR_W-1:0]        w_jmp_target;
  logic [ADDR_W-1:0]        w_pc_next;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_err_evt;
  logic [PTR_W-1:0]         w_wr_idx;
  logic [PTR_W-1:0]         w_ptr_next;
  logic [CNT_W-1:0]         w_count_next;

  assign w_pc_plus4   = r_pc + ADDR_W'(4);
  assign w_off_ext    = ADDR_W'(signed'(branch_off_i));
  assign w_br_target  = w_pc_plus4 + ADDR_W'(w_off_ext <<< 2);
  assign w_jmp_target = {w_pc_plus4[ADDR_W-1:IDX_W+2], jump_idx_i, 2'b00};

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_push    = link_i & (jump_i | jr_i);
  assign w_pop     = jr_i & ret_i & ~w_empty;
  // A return on an empty stack and a push that evicts the oldest entry both flag an error.
  assign w_err_evt = (jr_i & ret_i & w_empty) | (w_push & ~w_pop & w_full);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (jr_i) begin
      w_pc_next = w_pop ? r_ras[r_ptr] : jr_addr_i;
    end else if (jump_i) begin
      w_pc_next = w_jmp_target;
    end else if (branch_i) begin
      w_pc_next = w_br_target;
    end
  end

  always_comb begin
    w_wr_idx     = r_ptr;
    w_ptr_next   = r_ptr;
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_wr_idx   = r_ptr + PTR_W'(1);
      w_ptr_next = r_ptr + PTR_W'(1);
      if (!w_full) w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_ptr_next   = r_ptr - PTR_W'(1);
      w_count_next = r_count - CNT_W'(1);
    end
  end

  // NOTE: stack entries are reset too, so ras_top_o and contents are defined after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_pc    <= RESET_PC;
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (!stall_i) begin
      r_pc    <= w_pc_next;
      r_ptr   <= w_ptr_next;
      r_count <= w_count_next;
      if (w_push)    r_ras[w_wr_idx] <= w_pc_plus4;
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  assign pc_o        = r_pc;
  assign pc_plus4_o  = w_pc_plus4;
  assign ras_top_o   = w_empty ? '0 : r_ras[r_ptr];
  assign ras_count_o = r_count;
  assign ras_empty_o = w_empty;
  assign ras_full_o  = w_full;
  assign ras_err_o   = r_err;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: a behavioural model predicts each cycle's
// state, the prediction is queued at drive time and compared after the edge.
module tb_pc_seq_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, branch_i, jump_i, jr_i, ret_i, link_i;
  logic [15:0] branch_off_i;
  logic [25:0] jump_idx_i;
  logic [31:0] jr_addr_i;
  logic [31:0] pc_o, pc_plus4_o, ras_top_o;
  logic [2:0]  ras_count_o;
  logic        ras_empty_o, ras_full_o, ras_err_o;

  pc_seq_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
    .branch_off_i(branch_off_i), .jump_i(jump_i), .jump_idx_i(jump_idx_i),
    .jr_i(jr_i), .jr_addr_i(jr_addr_i), .ret_i(ret_i), .link_i(link_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .ras_top_o(ras_top_o),
    .ras_count_o(ras_count_o), .ras_empty_o(ras_empty_o),
    .ras_full_o(ras_full_o), .ras_err_o(ras_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] top;
    int          cnt;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_stack[$];
  logic [31:0] m_pc;
  bit          m_err;
  bit          m_valid = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0; jr_i = 1'b0;
    ret_i = 1'b0; link_i = 1'b0; branch_off_i = '0; jump_idx_i = '0; jr_addr_i = '0;
  endtask

  // Predict the effect of the inputs currently driven, clock once, compare, clear inputs.
  task automatic tick();
    logic [31:0] p4, tgt;
    bit          pop, push;
    exp_t        e, got;
    p4 = m_pc + 32'd4;
    if (m_valid) check("pc_plus4", pc_plus4_o, p4);
    if (!rst_i) begin
      m_pc = 32'h0; m_err = 1'b0; m_stack.delete(); m_valid = 1'b1;
    end else if (!stall_i) begin
      pop  = jr_i && ret_i && (m_stack.size() > 0);
      push = link_i && (jump_i || jr_i);
      if (jr_i) begin
        if (pop)        tgt = m_stack[$];
        else begin
          tgt = jr_addr_i;
          if (ret_i) m_err = 1'b1;
        end
      end else if (jump_i)   tgt = {p4[31:28], jump_idx_i, 2'b00};
      else if (branch_i)     tgt = p4 + ({{16{branch_off_i[15]}}, branch_off_i} << 2);
      else                   tgt = p4;
      if (pop && push) m_stack[m_stack.size()-1] = p4;
      else if (push) begin
        if (m_stack.size() == 4) begin
          void'(m_stack.pop_front());
          m_err = 1'b1;
        end
        m_stack.push_back(p4);
      end else if (pop) void'(m_stack.pop_back());
      m_pc = tgt;
    end
    e.pc  = m_pc;
    e.cnt = m_stack.size();
    e.top = (m_stack.size() > 0) ? m_stack[$] : 32'h0;
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    got = sb.pop_front();
    check("pc", pc_o, got.pc);
    check("ras_count", 32'(ras_count_o), 32'(got.cnt));
    check("ras_top", ras_top_o, got.top);
    check("ras_err", 32'(ras_err_o), 32'(got.err));
    check("ras_empty", 32'(ras_empty_o), 32'(got.cnt == 0));
    check("ras_full", 32'(ras_full_o), 32'(got.cnt == 4));
    idle_inputs();
  endtask

  task automatic jr_to(input logic [31:0] a);
    jr_i = 1'b1; jr_addr_i = a; tick();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk_i);

    // reset then free-running sequential fetch
    rst_i = 1'b0; tick();
    check("rst_pc", pc_o, 32'h0);
    tick(); tick(); tick();
    check("seq_pc", pc_o, 32'hC);

    // branches, including negative offset and address wrap
    jr_to(32'h100);
    branch_i = 1'b1; branch_off_i = 16'hFFFE; tick();
    check("br_back", pc_o, 32'hFC);
    jr_to(32'hFFFF_FFFC);
    branch_i = 1'b1; branch_off_i = 16'h0001; tick();
    check("br_wrap", pc_o, 32'h4);

    // region jump with link, then returns
    jr_to(32'h3000_0010);
    jump_i = 1'b1; link_i = 1'b1; jump_idx_i = 26'h40; tick();
    check("jal_pc", pc_o, 32'h3000_0100);
    check("jal_top", ras_top_o, 32'h3000_0014);
    jr_i = 1'b1; ret_i = 1'b1; jr_addr_i = 32'hDEAD_0000; tick();
    check("ret_pc", pc_o, 32'h3000_0014);
    jr_i = 1'b1; ret_i = 1'b1; jr_addr_i = 32'hDEAD_0000; tick();
    check("ret_empty_pc", pc_o, 32'hDEAD_0000);
    check("ret_empty_err", 32'(ras_err_o), 32'h1);

    // overflow: five pushes into a four-entry stack, then four LIFO returns
    rst_i = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      jump_i = 1'b1; link_i = 1'b1; jump_idx_i = 26'(32'h100 * (i + 1)); tick();
    end
    check("ovf_full", 32'(ras_full_o), 32'h1);
    check("ovf_err", 32'(ras_err_o), 32'h1);
    for (int i = 0; i < 4; i++) begin
      jr_i = 1'b1; ret_i = 1'b1; jr_addr_i = 32'h0BAD_0000; tick();
    end
    check("ovf_last_ret", pc_o, 32'h0000_0404);

    // pop and push together (jalr $ra), ignored ret/link, stall, priority
    rst_i = 1'b0; tick();
    jump_i = 1'b1; link_i = 1'b1; jump_idx_i = 26'h80; tick();
    jr_i = 1'b1; ret_i = 1'b1; link_i = 1'b1; tick();
    check("poppush_pc", pc_o, 32'h4);
    ret_i = 1'b1; jr_addr_i = 32'h55; tick();
    link_i = 1'b1; tick();
    stall_i = 1'b1; jump_i = 1'b1; link_i = 1'b1; jump_idx_i = 26'h3FF; tick();
    jr_i = 1'b1; jump_i = 1'b1; branch_i = 1'b1; jr_addr_i = 32'h1234_5678;
    branch_off_i = 16'h10; jump_idx_i = 26'h22; tick();
    check("prio_jr", pc_o, 32'h1234_5678);

    // reset wins over stall and a pending push
    jump_i = 1'b1; link_i = 1'b1; tick();
    rst_i = 1'b0; stall_i = 1'b1; jump_i = 1'b1; link_i = 1'b1; tick();
    check("rst_stall_pc", pc_o, 32'h0);
    check("rst_stall_cnt", 32'(ras_count_o), 32'h0);

    // random mix
    for (int i = 0; i < 300; i++) begin
      rst_i        = ($urandom_range(0, 49) != 0);
      stall_i      = ($urandom_range(0, 7) == 0);
      branch_i     = $urandom_range(0, 1);
      jump_i       = ($urandom_range(0, 3) == 0);
      jr_i         = ($urandom_range(0, 3) == 0);
      ret_i        = $urandom_range(0, 1);
      link_i       = $urandom_range(0, 1);
      branch_off_i = 16'($urandom);
      jump_idx_i   = 26'($urandom);
      jr_addr_i    = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
